// File: rtl/cp0_irq_if.sv
// Core <-> CP0 bus: command strobes from the controller, register views back from CP0.
interface cp0_irq_if;
  // Single-cycle strobes: mfc0/mtc0/exception/eret act on the rising edge they are
  // high for; there is no valid/ready handshake and CP0 never stalls the core.
  logic        mfc0;
  logic        mtc0;
  logic [31:0] pc;
  logic [4:0]  Rd;
  logic [31:0] wdata;
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] rdata;
  logic [31:0] status;
  logic [31:0] exc_addr;
  logic        intr_req;
  logic        timer_irq;

  modport master (
    output mfc0, mtc0, pc, Rd, wdata, exception, eret, cause,
    input  rdata, status, exc_addr, intr_req, timer_irq
  );

  modport slave (
    input  mfc0, mtc0, pc, Rd, wdata, exception, eret, cause,
    output rdata, status, exc_addr, intr_req, timer_irq
  );
endinterface

// File: rtl/cp0_irq.sv
// Coprocessor 0 with Status/Cause/EPC, synchronised external IRQs, software IRQs
// and an optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_irq #(
  parameter int          NUM_IRQ     = 5,
  parameter logic [31:0] EPC_OFFSET  = 32'd4,
  parameter int          STACK_SHIFT = 5,
  parameter logic [7:0]  IM_RESET    = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  cp0_irq_if.slave           bus
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  logic [31:0]        status_q;
  logic [31:0]        epc_q;
  logic [4:0]         exc_code_q;
  logic [1:0]         sw_ip_q;
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;
  logic [4:0]         hw_ip;
  logic               timer_pend;
  logic [31:0]        cause_val;

  logic wr_status, wr_cause, wr_epc;

  assign wr_status = bus.mtc0 && (bus.Rd == REG_STATUS);
  assign wr_cause  = bus.mtc0 && (bus.Rd == REG_CAUSE);
  assign wr_epc    = bus.mtc0 && (bus.Rd == REG_EPC);

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= {16'b0, IM_RESET, 8'b0};
      epc_q      <= 32'b0;
      exc_code_q <= 5'b0;
      sw_ip_q    <= 2'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      // Exception owns Status/Cause/EPC for its edge; eret and mtc0 to them are dropped.
      if (bus.exception) begin
        status_q   <= {status_q[31-STACK_SHIFT:0], {STACK_SHIFT{1'b0}}};
        exc_code_q <= bus.cause;
        epc_q      <= bus.pc - EPC_OFFSET;
      end else begin
        if (bus.eret)
          status_q <= {{STACK_SHIFT{1'b0}}, status_q[31:STACK_SHIFT]};
        else if (wr_status)
          status_q <= bus.wdata;
        if (wr_cause)
          sw_ip_q <= bus.wdata[9:8];
        if (wr_epc)
          epc_q <= bus.wdata;
      end
    end
  end

`ifdef CP0_TIMER_EN
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= 32'b0;
      compare_q    <= 32'hFFFF_FFFF;
      timer_pend_q <= 1'b0;
    end else begin
      if (bus.mtc0 && (bus.Rd == REG_COUNT))
        count_q <= bus.wdata;
      else
        count_q <= count_q + 32'd1;
      // Rewriting Compare acknowledges the timer, even on the edge a match lands.
      if (bus.mtc0 && (bus.Rd == REG_COMPARE)) begin
        compare_q    <= bus.wdata;
        timer_pend_q <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  assign timer_pend = timer_pend_q;
`else
  assign timer_pend = 1'b0;
`endif

  always_comb begin
    hw_ip = 5'b0;
    hw_ip[NUM_IRQ-1:0] = sync2_q;
  end

  assign cause_val = {16'b0, timer_pend, hw_ip, sw_ip_q, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    bus.rdata = 32'b0;
    if (bus.mfc0) begin
      case (bus.Rd)
`ifdef CP0_TIMER_EN
        REG_COUNT:   bus.rdata = count_q;
        REG_COMPARE: bus.rdata = compare_q;
`endif
        REG_STATUS:  bus.rdata = status_q;
        REG_CAUSE:   bus.rdata = cause_val;
        REG_EPC:     bus.rdata = epc_q;
        default:     bus.rdata = 32'b0;
      endcase
    end
  end

  assign bus.status    = status_q;
  assign bus.exc_addr  = epc_q;
  assign bus.timer_irq = timer_pend;
  assign bus.intr_req  = status_q[0] && ((status_q[15:8] & cause_val[15:8]) != 8'b0);

endmodule

// File: tb/tb_cp0_irq.sv
// Directed bench for cp0_irq: a register-level model checked every cycle plus
// hand-computed expectations at the interesting points of each scenario.
module tb_cp0_irq;

`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] irq;

  cp0_irq_if bus ();

  cp0_irq #(
    .NUM_IRQ(5), .EPC_OFFSET(32'd4), .STACK_SHIFT(5), .IM_RESET(8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .irq (irq),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register-level model ----------------
  logic [31:0] m_status, m_epc, m_count, m_compare;
  logic [4:0]  m_exc, m_hw, m_hist;
  logic [1:0]  m_sw;
  logic        m_timer, m_hit, m_valid = 1'b0;

  function automatic logic [31:0] m_cause();
    return {16'b0, 16'(m_timer) << 15 | 16'(m_hw) << 10 | 16'(m_sw) << 8 | 16'(m_exc) << 2};
  endfunction

  function automatic logic m_intr();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] && ((m_status[15:8] & c[15:8]) != 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] rd);
    case (rd)
      5'd9:    return TIMER ? m_count : 32'h0;
      5'd11:   return TIMER ? m_compare : 32'h0;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic wr(input logic [4:0] rd);
    return bus.mtc0 && (bus.Rd == rd);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_status = 32'h0; m_epc = 32'h0; m_count = 32'h0; m_compare = 32'hFFFF_FFFF;
      m_exc = 5'h0; m_sw = 2'h0; m_timer = 1'b0; m_hw = 5'h0; m_hist = 5'h0;
      m_valid = 1'b1;
    end else begin
      m_hit = TIMER && (m_count == m_compare);
      if (bus.exception) begin
        m_status = m_status << 5;
        m_exc    = bus.cause;
        m_epc    = bus.pc - 32'd4;
      end else begin
        if (bus.eret) m_status = m_status >> 5;
        else if (wr(5'd12)) m_status = bus.wdata;
        if (wr(5'd13)) m_sw = bus.wdata[9:8];
        if (wr(5'd14)) m_epc = bus.wdata;
      end
      if (TIMER) begin
        if (wr(5'd11)) begin m_compare = bus.wdata; m_timer = 1'b0; end
        else if (m_hit) m_timer = 1'b1;
        m_count = wr(5'd9) ? bus.wdata : m_count + 32'd1;
      end
      m_hw   = m_hist;
      m_hist = irq;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("status", bus.status, m_status);
      chk("exc_addr", bus.exc_addr, m_epc);
      chk("intr_req", {31'b0, bus.intr_req}, {31'b0, m_intr()});
      chk("timer_irq", {31'b0, bus.timer_irq}, {31'b0, m_timer});
      chk("rdata", bus.rdata, bus.mfc0 ? m_read(bus.Rd) : 32'h0);
    end
  end

  // ---------------- drivers ----------------
  logic [4:0] idle_rd [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
  int idle_ix = 0;

  task automatic set_idle();
    bus.mfc0 = 1'b1; bus.Rd = idle_rd[idle_ix]; idle_ix = (idle_ix + 1) % 7;
    bus.mtc0 = 1'b0; bus.wdata = 32'h0; bus.exception = 1'b0; bus.eret = 1'b0;
    bus.cause = 5'h0; bus.pc = 32'h0;
  endtask

  task automatic edge_done();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) edge_done();
  endtask

  task automatic do_mtc0(input logic [4:0] rd, input logic [31:0] d);
    bus.mfc0 = 1'b0; bus.mtc0 = 1'b1; bus.Rd = rd; bus.wdata = d;
    edge_done();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edge_done();
    rst = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] rd, input logic [31:0] exp);
    bus.mfc0 = 1'b1; bus.Rd = rd;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  initial begin
    irq = 5'h0;
    set_idle();
    do_reset();

    // Reset values
    rd_chk("rst_status", 5'd12, 32'h0000_0000);
    rd_chk("rst_compare", 5'd11, TIMER ? 32'hFFFF_FFFF : 32'h0);
    rd_chk("rst_cause", 5'd13, 32'h0000_0000);
    bus.mfc0 = 1'b0; #1;
    chk("rdata_no_mfc0", bus.rdata, 32'h0);
    chk("rst_epc", bus.exc_addr, 32'h0);
    chk("rst_intr", {31'b0, bus.intr_req}, 32'h0);
    chk("rst_timer", {31'b0, bus.timer_irq}, 32'h0);

    // Exception and return
    do_mtc0(5'd12, 32'h0000_0401);
    bus.exception = 1'b1; bus.cause = 5'd8; bus.pc = 32'h0040_0010;
    edge_done();
    chk("exc_status", bus.status, 32'h0000_8020);
    chk("exc_epc", bus.exc_addr, 32'h0040_000C);
    rd_chk("exc_cause", 5'd13, 32'h0000_0020);
    bus.eret = 1'b1;
    edge_done();
    chk("eret_status", bus.status, 32'h0000_0401);

    // External IRQ through the synchroniser
    irq = 5'b00001;
    tick(1);
    chk("irq_1cyc", {31'b0, bus.intr_req}, 32'h0);
    tick(1);
    chk("irq_2cyc", {31'b0, bus.intr_req}, 32'h1);
    rd_chk("irq_cause", 5'd13, 32'h0000_0420);
    irq = 5'b00000;
    tick(1);
    chk("irq_fall_1cyc", {31'b0, bus.intr_req}, 32'h1);
    tick(1);
    chk("irq_fall_2cyc", {31'b0, bus.intr_req}, 32'h0);

    // Reset discards in-flight synchroniser state
    irq = 5'b00001;
    tick(1);
    do_reset();
    tick(1);
    rd_chk("rst_flush_cause", 5'd13, 32'h0000_0000);
    tick(1);
    rd_chk("rst_resync_cause", 5'd13, 32'h0000_0400);
    irq = 5'b00000;
    tick(2);

    // Software interrupts
    do_reset();
    do_mtc0(5'd13, 32'hFFFF_FFFF);
    rd_chk("sw_cause", 5'd13, 32'h0000_0300);
    chk("sw_intr_masked", {31'b0, bus.intr_req}, 32'h0);
    do_mtc0(5'd12, 32'h0000_0101);
    chk("sw_intr", {31'b0, bus.intr_req}, 32'h1);

    // Collisions
    bus.exception = 1'b1; bus.eret = 1'b1; bus.mtc0 = 1'b1; bus.mfc0 = 1'b0;
    bus.Rd = 5'd14; bus.wdata = 32'hDEAD_BEEF; bus.pc = 32'h0000_0100; bus.cause = 5'd0;
    edge_done();
    chk("coll_epc", bus.exc_addr, 32'h0000_00FC);
    chk("coll_status", bus.status, 32'h0000_2020);
    bus.eret = 1'b1; bus.mtc0 = 1'b1; bus.mfc0 = 1'b0; bus.Rd = 5'd12; bus.wdata = 32'hFFFF_FFFF;
    edge_done();
    chk("eret_vs_mtc0", bus.status, 32'h0000_0101);
    bus.exception = 1'b1; bus.cause = 5'd3; bus.pc = 32'h0000_0200;
    bus.mtc0 = 1'b1; bus.mfc0 = 1'b0; bus.Rd = 5'd13; bus.wdata = 32'h0;
    edge_done();
    rd_chk("exc_vs_mtc0_cause", 5'd13, 32'h0000_030C);
    chk("exc_vs_mtc0_epc", bus.exc_addr, 32'h0000_01FC);

    // Timer
    do_reset();
    do_mtc0(5'd12, 32'h0000_0001);
    do_mtc0(5'd9, 32'h0);
    do_mtc0(5'd11, 32'd10);
    tick(9);
    rd_chk("count_at_10", 5'd9, TIMER ? 32'd10 : 32'd0);
    chk("timer_before", {31'b0, bus.timer_irq}, 32'h0);
    tick(1);
    chk("timer_set", {31'b0, bus.timer_irq}, TIMER ? 32'h1 : 32'h0);
    tick(3);
    chk("timer_sticky", {31'b0, bus.timer_irq}, TIMER ? 32'h1 : 32'h0);
    chk("timer_masked", {31'b0, bus.intr_req}, 32'h0);
    rd_chk("timer_cause", 5'd13, TIMER ? 32'h0000_8000 : 32'h0);
    do_mtc0(5'd11, 32'd100);
    chk("timer_clear", {31'b0, bus.timer_irq}, 32'h0);

    // Write sweep over every index; the model checks read-back each cycle
    for (int i = 0; i < 32; i++) begin
      do_mtc0(5'(i), 32'h1234_5600 + 32'(i));
      rd_chk("sweep_rd", 5'(i), m_read(5'(i)));
    end
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
